// File: rtl/serial_cmd_rx_pkg.sv
// Shared definitions for the host serial command link.
// Frame length, command codes and receiver state encoding.
package serial_cmd_rx_pkg;

  localparam int FRAME_LEN = 5;

  typedef enum logic [7:0] {
    CMD_ADDR     = 8'h01,
    CMD_LOAD     = 8'h02,
    CMD_WRITE    = 8'h03,
    CMD_READ     = 8'h04,
    CMD_READ_REQ = 8'h05,
    CMD_COUNT    = 8'h06,
    CMD_CONST    = 8'h07
  } cmd_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-flop synchroniser plus bit-timing FSM.
// Ports: clk, reset, rx in; data/strb/frame_err/busy out.
module uart_rx
  import serial_cmd_rx_pkg::*;
#(
  parameter int BAUD = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       strb,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(BAUD);
  localparam logic [TW-1:0] T_HALF = TW'(BAUD/2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(BAUD - 1);

  logic            rx_m;
  logic            rxs;
  logic            rxs_q;
  rx_state_e       state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      rx_m  <= rx;
      rxs   <= rx_m;
      rxs_q <= rxs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      strb      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      strb      <= 1'b0;
      frame_err <= 1'b0;
      timer     <= timer + 1'b1;
      unique case (state)
        RX_IDLE: begin
          timer <= '0;
          // The edge cycle itself is tick 0 of the start bit.
          if (!rxs && rxs_q) begin
            state <= RX_START;
            timer <= TW'(1);
          end
        end
        RX_START: begin
          if (timer == T_HALF) begin
            timer   <= '0;
            bit_idx <= '0;
            if (rxs) state <= RX_IDLE;
            else     state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            if (rxs) begin
              data  <= shreg;
              strb  <= 1'b1;
              state <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          timer <= '0;
          if (rxs) state <= RX_IDLE;
        end
        default: begin
          state <= RX_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: rtl/serial_cmd_rx.sv
// Host command receiver: UART bytes assembled into 5-byte frames.
// Ports: clk, reset, rx in; rx_data/rx_strb/cmd/data/cmd_valid/frame_err/busy out.
module serial_cmd_rx
  import serial_cmd_rx_pkg::*;
#(
  parameter int BAUD    = 104,
  parameter int TIMEOUT = 16*BAUD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_strb,
  output logic [7:0]  cmd,
  output logic [31:0] data,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int GW = $clog2(TIMEOUT + 1);

  logic          rx_busy;
  logic [2:0]    byte_cnt;
  logic [39:0]   sr;
  logic [39:0]   sr_next;
  logic [GW-1:0] gap;

  uart_rx #(
    .BAUD (BAUD)
  ) u_uart_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .strb      (rx_strb),
    .frame_err (frame_err),
    .busy      (rx_busy)
  );

  assign sr_next = {sr[31:0], rx_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt  <= '0;
      sr        <= '0;
      gap       <= '0;
      cmd       <= '0;
      data      <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      // A completed byte beats a timeout landing in the same cycle.
      if (rx_strb) begin
        gap <= '0;
        sr  <= sr_next;
        if (byte_cnt == 3'(FRAME_LEN - 1)) begin
          byte_cnt  <= '0;
          cmd       <= sr_next[39:32];
          data      <= sr_next[31:0];
          cmd_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (frame_err) begin
        byte_cnt <= '0;
        gap      <= '0;
      end else if (byte_cnt == '0) begin
        gap <= '0;
      end else if (!rx_busy) begin
        if (gap == GW'(TIMEOUT - 1)) begin
          byte_cnt <= '0;
          gap      <= '0;
        end else begin
          gap <= gap + 1'b1;
        end
      end
    end
  end

  assign busy = rx_busy || (byte_cnt != '0);

endmodule
